// File: rtl/run_mon_pkg.sv
// Shared types and constants for the run-termination monitor.
// The CRC helpers are only referenced when RUN_END_MON_PC_SIG_EN is defined.
package run_mon_pkg;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StDonePass = 2'd1,
    StDoneFail = 2'd2
  } run_state_e;

  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

  // Ceiling log2, never less than 1 so derived vectors always have a bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) begin
      w = w + 1;
    end
    return w;
  endfunction

  // One 32-bit word into a non-reflected CRC-32, MSB first.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/pc_loop_detect.sv
// PC history window and consecutive-hit counter; loop_fire_o flags the fetch that
// completes STABLE_CNT consecutive history hits.
module pc_loop_detect
  import run_mon_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LOOP_WIN   = 4,
  parameter int unsigned STABLE_CNT = 8,
  localparam int unsigned HitW      = clog2(STABLE_CNT + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              fetch_valid_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              loop_fire_o
);

  logic [ADDR_W-1:0] hist_q [LOOP_WIN];
  logic [LOOP_WIN-1:0] hist_vld_q;
  logic [HitW-1:0]     hit_cnt_q, hit_cnt_d;
  logic                hit;
  logic                upd;

  assign upd = en_i && fetch_valid_i;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < LOOP_WIN; i++) begin
      if (hist_vld_q[i] && (hist_q[i] == pc_i)) begin
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (upd) begin
      if (!hit) begin
        hit_cnt_d = '0;
      end else if (hit_cnt_q != HitW'(STABLE_CNT)) begin
        hit_cnt_d = hit_cnt_q + 1'b1;
      end
    end
  end

  assign loop_fire_o = upd && hit && (hit_cnt_q == HitW'(STABLE_CNT - 1));

  // Entry 0 is the newest PC; only the valid bits need clearing on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_vld_q <= '0;
      hit_cnt_q  <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      if (upd) begin
        hist_q[0]     <= pc_i;
        hist_vld_q[0] <= 1'b1;
        for (int i = 1; i < LOOP_WIN; i++) begin
          hist_q[i]     <= hist_q[i-1];
          hist_vld_q[i] <= hist_vld_q[i-1];
        end
      end
    end
  end

endmodule

// File: rtl/run_end_monitor.sv
// Run-termination checker for the CPU benches: ends a run on a settled fetch loop or a
// cycle budget and grades the final instruction. RUN_END_MON_PC_SIG_EN adds a PC CRC.
module run_end_monitor
  import run_mon_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INSTR_W    = 32,
  parameter int unsigned NUM_SIG    = 2,
  parameter int unsigned LOOP_WIN   = 4,
  parameter int unsigned STABLE_CNT = 8,
  parameter int unsigned MAX_CYCLES = 1000,
  localparam int unsigned CNT_W     = clog2(MAX_CYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_valid,
  input  logic [ADDR_W-1:0]          pc,
  input  logic [INSTR_W-1:0]         instr,
  input  logic [NUM_SIG*INSTR_W-1:0] end_sig,
  input  logic [NUM_SIG-1:0]         end_sig_en,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       loop_detected,
  output logic [ADDR_W-1:0]          loop_pc,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic [31:0]                pc_sig
);

  run_state_e        state_q;
  logic              done_q, pass_q, fail_q, loop_det_q;
  logic [ADDR_W-1:0] loop_pc_q;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic              in_run, loop_fire, timeout, term, matched;

  assign in_run = (state_q == StRun);

  pc_loop_detect #(
    .ADDR_W     (ADDR_W),
    .LOOP_WIN   (LOOP_WIN),
    .STABLE_CNT (STABLE_CNT)
  ) u_loop (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (in_run),
    .fetch_valid_i (fetch_valid),
    .pc_i          (pc),
    .loop_fire_o   (loop_fire)
  );

  always_comb begin
    matched = 1'b0;
    for (int k = 0; k < NUM_SIG; k++) begin
      if (end_sig_en[k] && (instr == end_sig[k*INSTR_W +: INSTR_W])) begin
        matched = 1'b1;
      end
    end
  end

  assign timeout = in_run && (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1));
  assign term    = loop_fire || timeout;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (in_run && (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    end
  end

  // Everything below only moves in RUN, so the DONE states hold all outputs frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      loop_det_q  <= 1'b0;
      loop_pc_q   <= '0;
      cycle_cnt_q <= '0;
    end else if (in_run) begin
      cycle_cnt_q <= cycle_cnt_d;
      if (term) begin
        state_q    <= matched ? StDonePass : StDoneFail;
        done_q     <= 1'b1;
        pass_q     <= matched;
        fail_q     <= !matched;
        loop_det_q <= loop_fire;
        if (loop_fire) begin
          loop_pc_q <= pc;
        end
      end
    end
  end

  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign loop_detected = loop_det_q;
  assign loop_pc       = loop_pc_q;
  assign cycle_cnt     = cycle_cnt_q;

`ifdef RUN_END_MON_PC_SIG_EN
  logic [31:0] pc_sig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_sig_q <= CRC32_INIT;
    end else if (in_run && fetch_valid) begin
      pc_sig_q <= crc32_step(pc_sig_q, 32'(pc));
    end
  end

  assign pc_sig = pc_sig_q;
`else
  assign pc_sig = 32'h0;
`endif

endmodule

// File: tb/tb_run_end_monitor.sv
// Directed bench for run_end_monitor: a default instance plus a MAX_CYCLES=50 instance
// driven from the same fetch stream.
module tb_run_end_monitor;

  localparam logic [31:0] SlotA = 32'hafa6_fffc;
  localparam logic [31:0] SlotB = 32'h1064_ffff;
`ifdef RUN_END_MON_PC_SIG_EN
  localparam logic [31:0] SigInit = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] SigInit = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] pc, instr;
  logic [63:0] end_sig;
  logic [1:0]  end_sig_en;

  logic        a_done, a_pass, a_fail, a_loop;
  logic [31:0] a_loop_pc, a_sig;
  logic [9:0]  a_cnt;
  logic        b_done, b_pass, b_fail, b_loop;
  logic [31:0] b_loop_pc, b_sig;
  logic [5:0]  b_cnt;
  logic [3:0]  a_flags, b_flags;

  int n_vec = 0;
  int n_err = 0;

  assign a_flags = {a_done, a_pass, a_fail, a_loop};
  assign b_flags = {b_done, b_pass, b_fail, b_loop};

  always #5 clk = ~clk;

  run_end_monitor dut (
    .clk (clk), .rst (rst), .fetch_valid (fetch_valid), .pc (pc), .instr (instr),
    .end_sig (end_sig), .end_sig_en (end_sig_en), .done (a_done), .pass (a_pass),
    .fail (a_fail), .loop_detected (a_loop), .loop_pc (a_loop_pc), .cycle_cnt (a_cnt),
    .pc_sig (a_sig)
  );

  run_end_monitor #(.MAX_CYCLES (50)) dut_to (
    .clk (clk), .rst (rst), .fetch_valid (fetch_valid), .pc (pc), .instr (instr),
    .end_sig (end_sig), .end_sig_en (end_sig_en), .done (b_done), .pass (b_pass),
    .fail (b_fail), .loop_detected (b_loop), .loop_pc (b_loop_pc), .cycle_cnt (b_cnt),
    .pc_sig (b_sig)
  );

  // Reference CRC in the data-first formulation.
  function automatic logic [31:0] crc_ref(input logic [31:0] crc, input logic [31:0] d);
    logic [31:0] c;
    c = crc ^ d;
    for (int i = 0; i < 32; i++) begin
      c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [31:0] p, input logic [31:0] i);
    fetch_valid = v;
    pc          = p;
    instr       = i;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_valid = 1'b1;
    pc = 32'hC;
    instr = SlotB;
    tick();
    rst = 1'b0;
    fetch_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (a_flags !== 4'b0000) begin n_err++;
      $display("FAIL reset_flags: got %b want 0000", a_flags); end
    n_vec++; if (b_flags !== 4'b0000) begin n_err++;
      $display("FAIL reset_flags_to: got %b want 0000", b_flags); end
    n_vec++; if (a_loop_pc !== 32'h0) begin n_err++;
      $display("FAIL reset_loop_pc: got %h want 0", a_loop_pc); end
    n_vec++; if (a_cnt !== 10'd0 || b_cnt !== 6'd0) begin n_err++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", a_cnt, b_cnt); end
    n_vec++; if (a_sig !== SigInit) begin n_err++;
      $display("FAIL reset_pc_sig: got %h want %h", a_sig, SigInit); end
  endtask

  task automatic test_self_loop();
    do_reset();
    end_sig_en = 2'b11;
    fetch(1, 32'h0, 32'h0);
    fetch(1, 32'h4, 32'h0);
    fetch(1, 32'h8, 32'h0);
    repeat (8) fetch(1, 32'hC, SlotB);
    n_vec++; if (a_done !== 1'b0) begin n_err++;
      $display("FAIL self_loop_early: got done=%b want 0", a_done); end
    fetch(1, 32'hC, SlotB);
    n_vec++; if (a_flags !== 4'b1101) begin n_err++;
      $display("FAIL self_loop_flags: got %b want 1101", a_flags); end
    n_vec++; if (a_loop_pc !== 32'hC) begin n_err++;
      $display("FAIL self_loop_pc: got %h want c", a_loop_pc); end
    n_vec++; if (a_cnt !== 10'd12) begin n_err++;
      $display("FAIL self_loop_cnt: got %0d want 12", a_cnt); end
    repeat (3) fetch(1, 32'h20, 32'h0);
    n_vec++; if (a_flags !== 4'b1101 || a_cnt !== 10'd12 || a_loop_pc !== 32'hC) begin
      n_err++;
      $display("FAIL self_loop_sticky: got %b cnt=%0d pc=%h want 1101 12 c",
               a_flags, a_cnt, a_loop_pc);
    end
  endtask

  task automatic test_two_loop();
    do_reset();
    end_sig_en = 2'b11;
    for (int k = 0; k < 9; k++) begin
      if (k % 2 == 0) fetch(1, 32'h10, 32'h0);
      else fetch(1, 32'h14, SlotA);
    end
    n_vec++; if (a_done !== 1'b0) begin n_err++;
      $display("FAIL two_loop_early: got done=%b want 0", a_done); end
    fetch(1, 32'h14, SlotA);
    n_vec++; if (a_flags !== 4'b1101 || a_loop_pc !== 32'h14) begin n_err++;
      $display("FAIL two_loop: got %b pc=%h want 1101 pc=14", a_flags, a_loop_pc); end
  endtask

  task automatic test_timeout();
    do_reset();
    end_sig_en = 2'b11;
    for (int k = 0; k < 49; k++) fetch(1, 32'h100 + 32'(4 * k), 32'h0);
    n_vec++; if (b_done !== 1'b0 || b_cnt !== 6'd49) begin n_err++;
      $display("FAIL timeout_early: got done=%b cnt=%0d want 0 49", b_done, b_cnt); end
    fetch(1, 32'h1C4, 32'h0);
    n_vec++; if (b_flags !== 4'b1010 || b_cnt !== 6'd50) begin n_err++;
      $display("FAIL timeout_fail: got %b cnt=%0d want 1010 50", b_flags, b_cnt); end
    n_vec++; if (b_loop_pc !== 32'h0) begin n_err++;
      $display("FAIL timeout_loop_pc: got %h want 0", b_loop_pc); end
    for (int k = 0; k < 5; k++) fetch(1, 32'h1C8 + 32'(4 * k), 32'h0);
    n_vec++; if (b_flags !== 4'b1010 || b_cnt !== 6'd50) begin n_err++;
      $display("FAIL timeout_frozen: got %b cnt=%0d want 1010 50", b_flags, b_cnt); end
    n_vec++; if (a_done !== 1'b0 || a_cnt !== 10'd55) begin n_err++;
      $display("FAIL long_budget: got done=%b cnt=%0d want 0 55", a_done, a_cnt); end
  endtask

  task automatic test_timeout_pass();
    do_reset();
    end_sig_en = 2'b11;
    for (int k = 0; k < 49; k++) fetch(1, 32'h400 + 32'(4 * k), 32'h0);
    fetch(1, 32'h4C4, SlotA);
    n_vec++; if (b_flags !== 4'b1100) begin n_err++;
      $display("FAIL timeout_pass: got %b want 1100", b_flags); end
  endtask

  task automatic test_loop_vs_timeout();
    do_reset();
    end_sig_en = 2'b11;
    repeat (41) fetch(0, 32'h200, 32'h0);
    repeat (8) fetch(1, 32'hC, SlotB);
    n_vec++; if (b_done !== 1'b0 || b_cnt !== 6'd49) begin n_err++;
      $display("FAIL tie_early: got done=%b cnt=%0d want 0 49", b_done, b_cnt); end
    fetch(1, 32'hC, SlotB);
    n_vec++; if (b_flags !== 4'b1101 || b_loop_pc !== 32'hC || b_cnt !== 6'd50) begin
      n_err++;
      $display("FAIL tie_loop_wins: got %b pc=%h cnt=%0d want 1101 c 50",
               b_flags, b_loop_pc, b_cnt);
    end
  endtask

  task automatic test_disabled_slot();
    do_reset();
    end_sig_en = 2'b01;
    repeat (9) fetch(1, 32'hC, SlotB);
    n_vec++; if (a_flags !== 4'b1011) begin n_err++;
      $display("FAIL disabled_slot: got %b want 1011", a_flags); end
    end_sig_en = 2'b11;
  endtask

  task automatic test_stall_gaps();
    do_reset();
    end_sig_en = 2'b11;
    repeat (8) begin
      fetch(1, 32'hC, SlotB);
      fetch(0, 32'h40, 32'h0);
    end
    n_vec++; if (a_done !== 1'b0) begin n_err++;
      $display("FAIL stall_early: got done=%b want 0", a_done); end
    fetch(1, 32'hC, SlotB);
    n_vec++; if (a_flags !== 4'b1101 || a_cnt !== 10'd17) begin n_err++;
      $display("FAIL stall_gaps: got %b cnt=%0d want 1101 17", a_flags, a_cnt); end
  endtask

  task automatic test_miss_clears();
    do_reset();
    end_sig_en = 2'b11;
    repeat (5) fetch(1, 32'hC, SlotB);
    fetch(1, 32'h20, 32'h0);
    repeat (7) fetch(1, 32'hC, SlotB);
    n_vec++; if (a_done !== 1'b0) begin n_err++;
      $display("FAIL miss_clears_early: got done=%b want 0", a_done); end
    fetch(1, 32'hC, SlotB);
    n_vec++; if (a_flags !== 4'b1101 || a_cnt !== 10'd14) begin n_err++;
      $display("FAIL miss_clears: got %b cnt=%0d want 1101 14", a_flags, a_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] crc;
    do_reset();
    end_sig_en = 2'b11;
    repeat (6) fetch(1, 32'hC, SlotB);
    do_reset();
    n_vec++; if (a_flags !== 4'b0000 || a_cnt !== 10'd0 || a_sig !== SigInit) begin
      n_err++;
      $display("FAIL reset_mid: got %b cnt=%0d sig=%h want 0000 0 %h",
               a_flags, a_cnt, a_sig, SigInit);
    end
    crc = 32'hFFFF_FFFF;
    repeat (8) begin
      fetch(1, 32'hC, SlotB);
      crc = crc_ref(crc, 32'hC);
    end
    n_vec++; if (a_done !== 1'b0) begin n_err++;
      $display("FAIL reset_mid_early: got done=%b want 0", a_done); end
    fetch(1, 32'hC, SlotB);
    crc = crc_ref(crc, 32'hC);
    n_vec++; if (a_flags !== 4'b1101 || a_cnt !== 10'd9) begin n_err++;
      $display("FAIL reset_mid_fresh: got %b cnt=%0d want 1101 9", a_flags, a_cnt); end
    fetch(1, 32'h44, 32'h0);
`ifdef RUN_END_MON_PC_SIG_EN
    n_vec++; if (a_sig !== crc) begin n_err++;
      $display("FAIL pc_sig: got %h want %h", a_sig, crc); end
`else
    n_vec++; if (a_sig !== 32'h0) begin n_err++;
      $display("FAIL pc_sig_off: got %h want 0 (ref %h)", a_sig, crc); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    fetch_valid = 1'b0;
    pc = 32'h0;
    instr = 32'h0;
    end_sig = {SlotB, SlotA};
    end_sig_en = 2'b11;
    test_reset();
    test_self_loop();
    test_two_loop();
    test_timeout();
    test_timeout_pass();
    test_loop_vs_timeout();
    test_disabled_slot();
    test_stall_gaps();
    test_miss_clears();
    test_reset_mid();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
